mk_rst_seq: RTL

//  Parametrised reset sequencer for the SASEBO-GIII controller clock/reset path.

---
 rtl/mk_rst_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mk_rst_seq.sv
// Staggered multi-channel reset sequencer: holds all channels until lock/config qualify,
// then releases them in ascending order. Optional heartbeat LED under RSTSEQ_HEARTBEAT_EN.
module mk_rst_seq #(
  parameter int NCH         = 4,
  parameter int CW          = 16,
  parameter int HOLD_CYC    = 65535,
  parameter int STAGGER_CYC = 16,
  parameter int SOFT_CYC    = 256,
  parameter int HB_W        = 20
) (
  input  logic           clk,
  input  logic           rstnin,
  input  logic           locked,
  input  logic           cfg_done,
  input  logic           soft_rst,
  output logic [NCH-1:0] rst,
  output logic           ready,
  output logic [1:0]     state,
  output logic           led_hb
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } st_t;

  localparam int              CHW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]   HOLD_END = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]   STAG_END = CW'(STAGGER_CYC - 1);
  localparam logic [CW-1:0]   SOFT_END = CW'(SOFT_CYC - 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NCH - 1);
  localparam logic [NCH-1:0]  CH_ONE   = NCH'(1);

  logic           locked_meta_r, locked_sync_r;
  logic           cfg_meta_r, cfg_sync_r;
  logic           qual_s;
  st_t            st_r;
  logic [CW-1:0]  cnt_r;
  logic [CHW-1:0] ch_r;
  logic [NCH-1:0] rst_r;
  logic           ready_r;

  // Two-flop synchronisers for the asynchronous status pins
  always_ff @(posedge clk or negedge rstnin) begin
    if (!rstnin) begin
      locked_meta_r <= 1'b0;
      locked_sync_r <= 1'b0;
      cfg_meta_r    <= 1'b0;
      cfg_sync_r    <= 1'b0;
    end else begin
      locked_meta_r <= locked;
      locked_sync_r <= locked_meta_r;
      cfg_meta_r    <= cfg_done;
      cfg_sync_r    <= cfg_meta_r;
    end
  end

  assign qual_s = locked_sync_r & cfg_sync_r;

  // Sequencer FSM; loss of qualifier outranks soft requests and counter terminals
  always_ff @(posedge clk or negedge rstnin) begin
    if (!rstnin) begin
      st_r    <= ST_HOLD;
      cnt_r   <= '0;
      ch_r    <= '0;
      rst_r   <= '1;
      ready_r <= 1'b0;
    end else begin
      case (st_r)
        ST_HOLD: begin
          if (!qual_s) begin
            cnt_r <= '0;
          end else if (cnt_r == HOLD_END) begin
            cnt_r    <= '0;
            rst_r[0] <= 1'b0;
            ch_r     <= CHW'(1);
            if (NCH == 1) begin
              st_r    <= ST_RUN;
              ready_r <= 1'b1;
            end else begin
              st_r <= ST_STAGGER;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_STAGGER: begin
          if (!qual_s) begin
            st_r    <= ST_HOLD;
            cnt_r   <= '0;
            rst_r   <= '1;
            ready_r <= 1'b0;
          end else if (cnt_r == STAG_END) begin
            cnt_r <= '0;
            rst_r <= rst_r & ~(CH_ONE << ch_r);
            if (ch_r == CH_LAST) begin
              st_r    <= ST_RUN;
              ready_r <= 1'b1;
            end else begin
              ch_r <= ch_r + CHW'(1);
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_RUN: begin
          if (!qual_s) begin
            st_r    <= ST_HOLD;
            cnt_r   <= '0;
            rst_r   <= '1;
            ready_r <= 1'b0;
          end else if (soft_rst) begin
            st_r    <= ST_SOFT;
            cnt_r   <= '0;
            rst_r   <= '1;
            ready_r <= 1'b0;
          end else begin
            st_r <= ST_RUN;
          end
        end
        ST_SOFT: begin
          if (!qual_s) begin
            st_r    <= ST_HOLD;
            cnt_r   <= '0;
            rst_r   <= '1;
            ready_r <= 1'b0;
          end else if (cnt_r == SOFT_END) begin
            cnt_r    <= '0;
            rst_r[0] <= 1'b0;
            ch_r     <= CHW'(1);
            if (NCH == 1) begin
              st_r    <= ST_RUN;
              ready_r <= 1'b1;
            end else begin
              st_r <= ST_STAGGER;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          st_r    <= ST_HOLD;
          cnt_r   <= '0;
          rst_r   <= '1;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign rst   = rst_r;
  assign ready = ready_r;
  assign state = st_r;

`ifdef RSTSEQ_HEARTBEAT_EN
  logic [HB_W-1:0] hb_cnt_r;

  // Heartbeat runs only while the system is fully out of reset
  always_ff @(posedge clk or negedge rstnin) begin
    if (!rstnin) begin
      hb_cnt_r <= '0;
    end else if (st_r == ST_RUN) begin
      hb_cnt_r <= hb_cnt_r + HB_W'(1);
    end else begin
      hb_cnt_r <= hb_cnt_r;
    end
  end

  assign led_hb = hb_cnt_r[HB_W-1];
`else
  // No heartbeat counter: the LED is a constant zero of the configured width reduced
  localparam logic [HB_W-1:0] HB_ZERO = '0;
  assign led_hb = |HB_ZERO;
`endif

endmodule
